// File: rtl/act_mem_sequencer.sv
// Activation memory sequencer for one LSTM layer: forward fill in timestep order, BPTT drain in reverse timestep order.
// Writes land one cycle after accept (1 word/cycle); reads take 2 cycles per word and hold the word while out_ready is low.
module act_mem_sequencer #(
  parameter int WIDTH      = 32,
  parameter int NUM        = 53,
  parameter int TIMESTEP   = 8,
  parameter int ADDR_WIDTH = 12,
  localparam int TS_W      = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1,
  localparam int IDX_W     = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_fwd,
  input  logic                  start_bwd,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [TS_W-1:0]       out_ts,
  output logic [IDX_W-1:0]      out_idx,
  input  logic                  out_ready,
  output logic                  mem_wr_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [WIDTH-1:0]      mem_i_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [WIDTH-1:0]      mem_o_b,
  output logic                  busy,
  output logic                  done_fwd,
  output logic                  done_bwd,
  output logic                  err
);

  localparam logic [TS_W-1:0]       LAST_TS   = TS_W'(TIMESTEP - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_A     = ADDR_WIDTH'(NUM);
  localparam logic [ADDR_WIDTH-1:0] BASE_LAST = ADDR_WIDTH'((TIMESTEP - 1) * NUM);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    BWD_ADDR = 2'd2,
    BWD_OUT  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [TS_W-1:0]         ts, ts_nxt;
  logic [ADDR_WIDTH-1:0]   base, base_nxt;
  logic                    fwd_valid, fwd_valid_nxt;
  logic                    in_ready_nxt;
  logic                    wr_nxt;
  logic [ADDR_WIDTH-1:0]   addr_a_nxt;
  logic [WIDTH-1:0]        data_a_nxt;
  logic                    done_fwd_nxt, done_bwd_nxt, err_nxt;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  // base tracks ts*NUM so the address needs only an adder
  assign cur_addr = base + ADDR_WIDTH'(idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      ts         <= '0;
      base       <= '0;
      fwd_valid  <= 1'b0;
      in_ready   <= 1'b0;
      mem_wr_a   <= 1'b0;
      mem_addr_a <= '0;
      mem_i_a    <= '0;
      done_fwd   <= 1'b0;
      done_bwd   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      ts         <= ts_nxt;
      base       <= base_nxt;
      fwd_valid  <= fwd_valid_nxt;
      in_ready   <= in_ready_nxt;
      mem_wr_a   <= wr_nxt;
      mem_addr_a <= addr_a_nxt;
      mem_i_a    <= data_a_nxt;
      done_fwd   <= done_fwd_nxt;
      done_bwd   <= done_bwd_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    ts_nxt        = ts;
    base_nxt      = base;
    fwd_valid_nxt = fwd_valid;
    in_ready_nxt  = in_ready;
    wr_nxt        = 1'b0;
    addr_a_nxt    = mem_addr_a;
    data_a_nxt    = mem_i_a;
    done_fwd_nxt  = 1'b0;
    done_bwd_nxt  = 1'b0;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start_fwd) begin
          state_nxt     = FWD;
          idx_nxt       = '0;
          ts_nxt        = '0;
          base_nxt      = '0;
          fwd_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end else if (start_bwd) begin
          if (fwd_valid) begin
            state_nxt = BWD_ADDR;
            ts_nxt    = LAST_TS;
            base_nxt  = BASE_LAST;
            idx_nxt   = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      FWD: begin
        err_nxt = start_fwd || start_bwd;
        if (in_valid && in_ready) begin
          wr_nxt     = 1'b1;
          addr_a_nxt = cur_addr;
          data_a_nxt = in_data;
          if (idx == LAST_IDX) begin
            if (ts == LAST_TS) begin
              in_ready_nxt  = 1'b0;
              done_fwd_nxt  = 1'b1;
              fwd_valid_nxt = 1'b1;
              state_nxt     = IDLE;
              idx_nxt       = '0;
              ts_nxt        = '0;
              base_nxt      = '0;
            end else begin
              idx_nxt  = '0;
              ts_nxt   = ts + 1'b1;
              base_nxt = base + NUM_A;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      BWD_ADDR: begin
        err_nxt   = start_fwd || start_bwd;
        state_nxt = BWD_OUT;
      end

      BWD_OUT: begin
        err_nxt = start_fwd || start_bwd;
        if (out_ready) begin
          state_nxt = BWD_ADDR;
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (ts == '0) begin
              done_bwd_nxt = 1'b1;
              state_nxt    = IDLE;
              base_nxt     = '0;
            end else begin
              ts_nxt   = ts - 1'b1;
              base_nxt = base - NUM_A;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Port B address stays put through BWD_OUT so a stalled word keeps re-reading the same location
  assign mem_addr_b = cur_addr;
  assign out_valid  = (state == BWD_OUT);
  assign out_data   = out_valid ? mem_o_b : '0;
  assign out_ts     = ts;
  assign out_idx    = idx;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_act_mem_sequencer.sv
// Scoreboard bench for act_mem_sequencer with a behavioural memory and a timestep-ordered reference model.
module tb_act_mem_sequencer;
  localparam int W     = 32;
  localparam int N     = 4;
  localparam int T     = 3;
  localparam int AW    = 12;
  localparam int TSW   = 2;
  localparam int IXW   = 2;
  localparam int DEPTH = N * T;

  logic           clk = 1'b0;
  logic           rst, start_fwd, start_bwd, in_valid, in_ready;
  logic           out_valid, out_ready, mem_wr_a, busy, done_fwd, done_bwd, err;
  logic [W-1:0]   in_data, out_data, mem_i_a, mem_o_b;
  logic [TSW-1:0] out_ts;
  logic [IXW-1:0] out_idx;
  logic [AW-1:0]  mem_addr_a, mem_addr_b;

  always #5 clk = ~clk;

  act_mem_sequencer #(.WIDTH(W), .NUM(N), .TIMESTEP(T), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start_fwd(start_fwd), .start_bwd(start_bwd),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ts(out_ts), .out_idx(out_idx),
    .out_ready(out_ready), .mem_wr_a(mem_wr_a), .mem_addr_a(mem_addr_a), .mem_i_a(mem_i_a),
    .mem_addr_b(mem_addr_b), .mem_o_b(mem_o_b), .busy(busy),
    .done_fwd(done_fwd), .done_bwd(done_bwd), .err(err)
  );

  // Dual-port memory with registered read on port B
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_a && int'(mem_addr_a) < DEPTH) mem[int'(mem_addr_a)] <= mem_i_a;
    mem_o_b <= (int'(mem_addr_b) < DEPTH) ? mem[int'(mem_addr_b)] : '0;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  typedef struct packed {
    logic [TSW-1:0] ts;
    logic [IXW-1:0] idx;
    logic [W-1:0]   data;
  } rd_t;

  logic [W-1:0] model_mem [DEPTH];
  wr_t wq[$];
  rd_t rq[$];

  // Write monitor
  wr_t we;
  always @(negedge clk) begin
    if (mem_wr_a) begin
      chk("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        we = wq.pop_front();
        chk("wr_addr", 64'(mem_addr_a), 64'(we.addr));
        chk("wr_data", 64'(mem_i_a), 64'(we.data));
      end
    end
  end

  // Read monitor
  rd_t re;
  logic hs, prev_hs = 1'b0, last_hs = 1'b0;
  int done_cnt = 0;
  always @(negedge clk) begin
    hs = out_valid && out_ready;
    if (last_hs) begin
      chk("done_bwd_after_last", 64'(done_bwd), 64'd1);
      done_cnt++;
    end else if (done_bwd) begin
      chk("done_bwd_spurious", 64'(done_bwd), 64'd0);
    end
    if (prev_hs) chk("out_valid_gap", 64'(out_valid), 64'd0);
    if (hs) begin
      chk("rd_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) begin
        re = rq.pop_front();
        chk("rd_ts", 64'(out_ts), 64'(re.ts));
        chk("rd_idx", 64'(out_idx), 64'(re.idx));
        chk("rd_data", 64'(out_data), 64'(re.data));
      end
    end
    last_hs = hs && (rq.size() == 0);
    prev_hs = hs;
  end

  // Called at posedge+1; starts are sampled on the following edge
  task automatic pulse(input logic f, input logic b);
    start_fwd = f;
    start_bwd = b;
    @(posedge clk); #1;
    start_fwd = 1'b0;
    start_bwd = 1'b0;
  endtask

  task automatic fill(input int nwords, input bit rnd_valid, input bit rnd_data);
    int k = 0;
    int budget = 0;
    while (k < nwords && budget < 1000) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = rnd_data ? W'($urandom) : W'(32'h100 + k);
      @(negedge clk);
      chk("in_ready_fwd", 64'(in_ready), 64'd1);
      if (in_valid) begin
        // linear position of (ts, idx) in timestep-major order
        model_mem[(k / N) * N + (k % N)] = in_data;
        wq.push_back('{addr: AW'((k / N) * N + (k % N)), data: in_data});
        k++;
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    if (k < nwords) chk("fill_timeout", 64'(k), 64'(nwords));
  endtask

  task automatic check_fill_done();
    @(negedge clk);
    chk("done_fwd", 64'(done_fwd), 64'd1);
    chk("done_fwd_wr", 64'(mem_wr_a), 64'd1);
    chk("done_fwd_addr", 64'(mem_addr_a), 64'(DEPTH - 1));
    chk("in_ready_after", 64'(in_ready), 64'd0);
    chk("busy_after_fwd", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd_ready, input bit do_stall);
    int  d0 = done_cnt;
    int  budget = 0;
    bit  stalled = 1'b0;
    for (int t = T - 1; t >= 0; t--)
      for (int i = 0; i < N; i++)
        rq.push_back('{ts: TSW'(t), idx: IXW'(i), data: model_mem[t * N + i]});
    pulse(1'b0, 1'b1);
    while (done_cnt == d0 && budget < 500) begin
      if (do_stall && !stalled && out_valid && out_ts == TSW'(1) && out_idx == IXW'(2)) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'(out_data), 64'(model_mem[1 * N + 2]));
          chk("stall_idx", 64'(out_idx), 64'd2);
          @(posedge clk); #1;
        end
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b0;
    chk("drain_finished", 64'(done_cnt != d0), 64'd1);
    if (do_stall) chk("stall_seen", 64'(stalled), 64'd1);
    @(negedge clk);
    chk("busy_after_bwd", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_ts_idx"}, 64'({out_ts, out_idx}), 64'd0);
    chk({tag, "_mem_wr_a"}, 64'(mem_wr_a), 64'd0);
    chk({tag, "_mem_addr_a"}, 64'(mem_addr_a), 64'd0);
    chk({tag, "_mem_i_a"}, 64'(mem_i_a), 64'd0);
    chk({tag, "_mem_addr_b"}, 64'(mem_addr_b), 64'd0);
    chk({tag, "_pulses"}, 64'({done_fwd, done_bwd, err}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_fwd = 1'b0; start_bwd = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;

    // Drain request with no prior fill
    pulse(1'b0, 1'b1);
    @(negedge clk);
    chk("err_no_fwd", 64'(err), 64'd1);
    chk("busy_no_fwd", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_one_cycle", 64'(err), 64'd0);
    @(posedge clk); #1;

    // Simultaneous starts: forward wins
    pulse(1'b1, 1'b1);
    @(negedge clk);
    chk("both_busy", 64'(busy), 64'd1);
    chk("both_err", 64'(err), 64'd0);
    chk("fwd_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    // Restart while busy is rejected
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("err_busy", 64'(err), 64'd1);
    chk("busy_kept", 64'(busy), 64'd1);
    @(posedge clk); #1;

    fill(DEPTH, 1'b0, 1'b0);
    check_fill_done();

    drain(1'b0, 1'b1);
    drain(1'b1, 1'b0);

    // Reset mid-fill
    pulse(1'b1, 1'b0);
    fill(5, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset");
    @(posedge clk); #1;
    pulse(1'b0, 1'b1);
    @(negedge clk);
    chk("err_after_reset", 64'(err), 64'd1);
    chk("busy_after_reset", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Random valid and data, random ready
    pulse(1'b1, 1'b0);
    fill(DEPTH, 1'b1, 1'b1);
    check_fill_done();
    drain(1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
